// File: rtl/obstacle_pkg.sv
// Shared obstacle constants, type encoding and size decode.
// Used by the scroller, the single-obstacle FSM and the collision judge.
package obstacle_pkg;

  localparam logic [1:0] GS_UNBEGIN = 2'b00;
  localparam logic [1:0] GS_RUNNING = 2'b01;
  localparam logic [1:0] GS_DEAD    = 2'b10;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int W_NARROW = 50;
  localparam int W_MID    = 100;
  localparam int W_WIDE   = 150;
  localparam int H_LOW    = 70;
  localparam int H_TALL   = 100;

  localparam int BIRD_OFFSET = 60;

  typedef logic [3:0] obs_sel_t;

  function automatic logic [10:0] obs_width(obs_sel_t sel);
    logic [10:0] w;
    unique case (sel[1:0])
      2'd0: w = 11'(W_NARROW);
      2'd1: w = 11'(W_MID);
      2'd2: w = 11'(W_WIDE);
      2'd3: w = 11'(W_NARROW);
    endcase
    return w;
  endfunction

  function automatic logic [9:0] obs_height(obs_sel_t sel);
    return sel[2] ? 10'(H_TALL) : 10'(H_LOW);
  endfunction

  // Birds fly above the ground line by a fixed offset.
  function automatic logic [9:0] obs_base_y(obs_sel_t sel, logic [9:0] y);
    return sel[3] ? y + 10'(BIRD_OFFSET) : y;
  endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: holds active/X/Y/type and scrolls left while running.
// Also answers the per-pixel hit query for its own rectangle.
module obstacle_slot
  import obstacle_pkg::*;
(
  input  logic               bgndclk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               run_i,
  input  logic               load_i,
  input  obs_sel_t           sel_i,
  input  logic [9:0]         y_i,
  input  logic [3:0]         speed_i,
  input  logic signed [11:0] qx_i,
  input  logic signed [11:0] qy_i,
  output logic               active_o,
  output logic               retire_o,
  output logic signed [11:0] xw_o,
  output logic               hit_o,
  output obs_sel_t           sel_o
);

  localparam logic signed [10:0] X_PARK = 11'(SCREEN_W + 50);
  localparam logic signed [10:0] X_LOAD = 11'(SCREEN_W);

  logic               active_q, active_d;
  logic signed [10:0] x_q, x_d;
  logic [9:0]         y_q, y_d;
  obs_sel_t           sel_q, sel_d;

  logic signed [11:0] x_w, w_w, x_nx, xw_nx;
  logic signed [11:0] ylo, yhi;

  always_comb begin
    x_w   = {x_q[10], x_q};
    w_w   = $signed({1'b0, obs_width(sel_q)});
    xw_o  = x_w + w_w;
    x_nx  = x_w - $signed({8'd0, speed_i});
    xw_nx = x_nx + w_w;
    ylo   = $signed({2'b00, y_q});
    yhi   = ylo + $signed({2'b00, obs_height(sel_q)});
    retire_o = run_i && active_q && (xw_nx <= 12'sd0);
    hit_o = active_q
         && (qx_i >= x_w) && (qx_i < xw_o)
         && (qy_i >= ylo) && (qy_i < yhi);
  end

  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    sel_d    = sel_q;
    if (clear_i) begin
      active_d = 1'b0;
      x_d      = X_PARK;
      y_d      = '0;
      sel_d    = '0;
    end else if (load_i) begin
      active_d = 1'b1;
      x_d      = X_LOAD;
      y_d      = y_i;
      sel_d    = sel_i;
    end else if (run_i && active_q) begin
      x_d = x_nx[10:0];
      if (retire_o) active_d = 1'b0;
    end
  end

  always_ff @(posedge bgndclk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      x_q      <= X_PARK;
      y_q      <= '0;
      sel_q    <= '0;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sel_q    <= sel_d;
    end
  end

  assign active_o = active_q;
  assign sel_o    = sel_q;

endmodule

// File: rtl/obstacle_scroller.sv
// Multi-slot obstacle scroller: spawn arbitration with a minimum gap,
// retire counting, and a lowest-index-wins pixel hit query.
module obstacle_scroller
  import obstacle_pkg::*;
#(
  parameter int N_SLOTS = 4,
  parameter int MIN_GAP = 120,
  parameter int CNT_W   = 16,
  localparam int SW     = $clog2(N_SLOTS)
) (
  input  logic               bgndclk,
  input  logic               rst,
  input  logic [1:0]         gamestate,
  input  logic [3:0]         speed,
  input  logic               spawn_req,
  input  logic [3:0]         spawn_sel,
  input  logic [9:0]         spawn_y,
  output logic               spawn_ack,
  input  logic [9:0]         px,
  input  logic [8:0]         py,
  output logic               pix_hit,
  output logic [SW-1:0]      pix_slot,
  output logic [3:0]         pix_sel,
  output logic [N_SLOTS-1:0] active_mask,
  output logic               full,
  output logic [CNT_W-1:0]   passed_cnt
);

  localparam int CW1 = CNT_W + 1;

  logic running, clear;
  logic [N_SLOTS-1:0] act, ret, hit, load;
  logic signed [11:0] xw [N_SLOTS];
  obs_sel_t           sel [N_SLOTS];
  logic signed [11:0] qx, qy;
  logic [9:0]         y_dec;

  logic [SW-1:0]    newest_q, newest_d, free_idx;
  logic             gap_ok, accept;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   pop, sum;

  assign running = (gamestate == GS_RUNNING);
  assign clear   = !running && (gamestate != GS_DEAD);
  assign qx      = $signed({2'b00, px});
  assign qy      = $signed(12'(SCREEN_H)) - $signed({3'b000, py});
  assign y_dec   = obs_base_y(spawn_sel, spawn_y);

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    assign load[i] = accept && (free_idx == SW'(i));
    obstacle_slot u_slot (
      .bgndclk  (bgndclk),
      .rst      (rst),
      .clear_i  (clear),
      .run_i    (running),
      .load_i   (load[i]),
      .sel_i    (spawn_sel),
      .y_i      (y_dec),
      .speed_i  (speed),
      .qx_i     (qx),
      .qy_i     (qy),
      .active_o (act[i]),
      .retire_o (ret[i]),
      .xw_o     (xw[i]),
      .hit_o    (hit[i]),
      .sel_o    (sel[i])
    );
  end

  // Pre-edge mask: a slot retiring this edge is not yet free.
  always_comb begin
    free_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--)
      if (!act[i]) free_idx = SW'(i);
  end

  assign gap_ok = !act[newest_q]
               || (xw[newest_q] <= $signed(12'(SCREEN_W - MIN_GAP)));
  assign accept = running && spawn_req && !full && gap_ok;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_SLOTS; i++)
      pop = pop + CW1'(ret[i]);
    sum = {1'b0, cnt_q} + pop;
  end

  always_comb begin
    newest_d = newest_q;
    cnt_d    = cnt_q;
    ack_d    = accept;
    if (clear) begin
      newest_d = '0;
      cnt_d    = '0;
    end else begin
      if (accept) newest_d = free_idx;
      cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge bgndclk or posedge rst) begin
    if (rst) begin
      newest_q <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
    end else begin
      newest_q <= newest_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    pix_hit  = |hit;
    pix_slot = '0;
    pix_sel  = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--)
      if (hit[i]) begin
        pix_slot = SW'(i);
        pix_sel  = sel[i];
      end
  end

  assign spawn_ack   = ack_q;
  assign active_mask = act;
  assign full        = &act;
  assign passed_cnt  = cnt_q;

endmodule

// File: doc/obstacle_scroller.md
Name: obstacle_scroller

Overview:
- Multi-slot successor to the single-obstacle drawer: tracks up to N_SLOTS concurrent obstacles, each with its own type, X and Y.
- Scrolls all active obstacles left by a programmable speed per bgndclk tick.
- Accepts spawns from the obstacle generator over a req/ack handshake, enforcing a minimum horizontal gap, and counts obstacles that have been cleared.
- Provides a combinational per-pixel hit query to the renderer and collision logic.

Parameters:
- N_SLOTS, 4, number of concurrent obstacle slots (2..8).
- MIN_GAP, 120, minimum pixels between the right edge of the newest obstacle and the screen's right edge before the next spawn is accepted.
- CNT_W, 16, width of the passed-obstacle counter.

Ports:
- bgndclk  in  1  scroll clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- gamestate  in  2  00 UnBegin, 01 Running, 10 Dead, 11 treated as UnBegin.
- speed  in  4  pixels subtracted from X per tick; 0 means no motion.
- spawn_req  in  1  generator requests a new obstacle; held until spawn_ack.
- spawn_sel  in  4  type of the requested obstacle.
- spawn_y  in  10  base Y (ground-up coordinates) of the requested obstacle.
- spawn_ack  out  1  one-tick pulse; spawn accepted this edge.
- px  in  10  pixel X.
- py  in  9  raw pixel Y (top-down).
- pix_hit  out  1  pixel lies inside an active obstacle.
- pix_slot  out  $clog2(N_SLOTS)  index of the hit slot.
- pix_sel  out  4  type of the hit slot.
- active_mask  out  N_SLOTS  per-slot active flag.
- full  out  1  all slots active.
- passed_cnt  out  CNT_W  obstacles retired since UnBegin; saturating.

Behaviour:
- Reset: all slots inactive; X = SCREEN_W + 50, Y = 0, sel = 0; spawn_ack = 0; passed_cnt = 0; newest pointer = 0.
- Type decode:
  - sel[1:0] selects width: 0→50, 1→100, 2→150, 3→50.
  - sel[2] selects height: 0→70, 1→100.
  - sel[3] marks a bird; a bird's stored Y = spawn_y + BIRD_OFFSET (60).
- X is signed 11-bit. All comparisons are signed. Width is zero-extended to 11 bits.
- UnBegin: clear all slots to their reset values; clear passed_cnt. No ack.
- Dead: freeze every register. spawn_ack = 0. The pixel query stays live.
- Running, per tick, each active slot:
  - X_next = X − speed.
  - If X_next + W ≤ 0, the slot goes inactive at this edge.
  - passed_cnt increases by the number of slots retiring this edge (popcount), saturating at all-ones.
- Spawn acceptance, Running only. spawn_ack = 1 iff all of:
  - spawn_req = 1;
  - at least one slot is inactive, judged on the mask before this edge;
  - the newest slot is inactive, or its pre-move X + W ≤ SCREEN_W − MIN_GAP.
- On accept:
  - The lowest-index inactive slot loads X = SCREEN_W (640), sel = spawn_sel, and the decoded Y.
  - That slot becomes active and becomes the newest.
  - A freshly loaded slot does not move on its load edge.
- Same-edge spawn and retire: a slot retiring on this edge is not eligible for the spawn until the next edge.
- spawn_ack is registered. The requester drops spawn_req on the cycle after it sees ack. A req still high after ack is treated as a new request.
- Pixel query (combinational, zero latency):
  - y = 480 − py.
  - A slot hits if it is active, X ≤ px < X + W, and Y ≤ y < Y + H.
  - The lowest-index hit wins and drives pix_slot and pix_sel.
  - When nothing hits: pix_hit = 0, pix_slot = 0, pix_sel = 0.
- full = &active_mask.

Decomposition:
- Shared package obstacle_pkg holds:
  - gamestate localparams;
  - SCREEN_W, SCREEN_H;
  - width and height constants;
  - BIRD_OFFSET;
  - obs_sel_t typedef;
  - width/height decode functions (shared with the existing obstacle FSM and judge).
- Sub-module obstacle_slot, one per slot, generated N_SLOTS times. It holds active, X, Y and sel, and implements load/move/retire/clear. It outputs its active flag, a retire pulse, its X+W, and a combinational hit.
- The top level holds spawn arbitration, the newest pointer, the popcount counter and the hit priority encoder.

Test Plan:
- Reset then Running, speed = 2, spawn_req with sel = 0, y = 102 → ack on 1st edge. Slot0 X = 640, then 638 and 636 on the next two edges. Pixel px = 638, py = 368 (y = 112) → pix_hit = 1, pix_slot = 0.
- Second req held right after the first, MIN_GAP = 120, speed = 10, W = 50 → no ack until slot0 X + 50 ≤ 520 (X = 470). Ack then lands in slot1 with X = 640.
- Fill all 4 slots → full = 1. A 5th req gets no ack until the first retire. A slot retiring on the same edge as a pending req is spawned into one edge later.
- Slot at X = −48, W = 50, speed = 4 → retires (X_next + W = −2 ≤ 0). passed_cnt 0→1. Two slots retiring on the same edge → +2.
- Bird spawn, sel = 4'b1000, y = 102 → stored Y = 162. Pixel at y = 150 inside X range → no hit; y = 170 → hit.
- Running→Dead mid-scroll → X values frozen and spawn_req ignored. Dead→UnBegin → all slots cleared, passed_cnt = 0. Async rst pulse mid-tick → immediate clear.
